imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares the single port of the 32x64k instruction/data memory between the fetch unit and the load/store unit.
- Arbitrates one access per cycle, drives the memory address, write-enable and data pins, and routes the one-cycle-latency read data back to the owning requester.
- Fixed load/store priority, with a starvation guard that guarantees fetch progress.
- Sits between ifetch, the LSU and DP_mem32x64k in top.

Parameters:
- ADDR, 16, memory address width (words)
- WORD, 32, data width
- STARVE_MAX, 4, consecutive denied fetch-request cycles before fetch is forced to win; range 1..15

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch read request; held until granted
- if_addr_i  in  ADDR  fetch address; stable while if_req_i is high
- if_flush_i  in  1  discard any in-flight fetch response
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  WORD  fetch read data
- ls_req_i  in  1  load/store request; held until granted
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR  load/store address
- ls_wdata_i  in  WORD  store data
- ls_gnt_o  out  1  load/store request accepted this cycle
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  WORD  load data
- mem_addr_o  out  ADDR  to memory A
- mem_we_o  out  1  to memory W
- mem_d_o  out  WORD  to memory D
- mem_q_i  in  WORD  from memory Q; valid the cycle after its address is presented

Behaviour:
- Reset:
  - While rst=0: all outputs 0, owner=IDLE, starve_cnt=0.
  - Any response in flight at reset assertion is dropped; no rvalid after reset deassertion.
- Grant logic is combinational from the current request inputs and starve_cnt.
  - At most one of if_gnt_o / ls_gnt_o is high in any cycle.
  - A request is consumed in the cycle its gnt is high.
- Priority:
  - ls wins when both request, unless starve_cnt == STARVE_MAX; then if wins.
  - A lone requester always wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) in each cycle if_req_i=1 and if_gnt_o=0.
  - Clears on any if grant or when if_req_i=0.
- Memory pins, same cycle as the grant:
  - mem_addr_o = winner's address.
  - mem_we_o = ls_we_i when ls wins, else 0.
  - mem_d_o = ls_wdata_i when ls wins, else 0.
  - No grant: mem_addr_o=0, mem_we_o=0, mem_d_o=0.
- Response state machine (owner register, updated each clock):
  - IDLE -> RD_IF on an if grant.
  - IDLE -> RD_LS on an ls load grant.
  - An ls store grant leaves owner IDLE.
  - From any state, the next owner is set by this cycle's grant (back-to-back accesses supported, full throughput of 1 access/cycle).
  - With no grant, owner -> IDLE.
- Read response (exactly 1-cycle latency):
  - owner==RD_IF: if_rvalid_o=1, if_rdata_o=mem_q_i.
  - owner==RD_LS: ls_rvalid_o=1, ls_rdata_o=mem_q_i.
  - rdata outputs are 0 when their rvalid is 0.
  - Stores produce no rvalid; the grant cycle is completion.
- Flush:
  - if_flush_i=1 while owner==RD_IF suppresses if_rvalid_o in that cycle.
  - if_flush_i=1 in an if grant cycle marks that response dropped, so no if_rvalid_o the next cycle.
  - The grant itself is not revoked.
  - Flush never affects ls responses.
- Simultaneous events: a new grant issues in the same cycle a previous response is returned; no bubble.

Optional Feature:
- Macro IMEM_DMEM_ARB_STATS_EN.
- Defined: adds outputs stat_if_o, stat_ls_o and stat_conflict_o, each 32-bit.
  - stat_if_o counts if grants.
  - stat_ls_o counts ls grants.
  - stat_conflict_o counts cycles with both requests high.
  - All three saturate at all-ones and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst=0 with both requests high -> all gnt/rvalid/mem outputs 0. Release rst -> if grant in first cycle if only if_req_i=1.
- Back-to-back fetch: if_req_i=1 with if_addr_i=0x0010,0x0011,0x0012 on consecutive cycles, memory preloaded -> if_gnt_o high 3 cycles; if_rvalid_o high the following 3 cycles with the matching words.
- Contention and starvation: both requests high continuously, STARVE_MAX=4 -> ls granted cycles 0-3, if granted cycle 4, ls cycles 5-8, if cycle 9.
- Store then load: ls store addr 0x0100 data 0xDEADBEEF, next cycle load 0x0100 -> mem_we_o=1 only in the store cycle; ls_rvalid_o=1 with 0xDEADBEEF one cycle after the load grant; no rvalid for the store.
- Flush: if grant at 0x0020 with if_flush_i=1 in the response cycle -> if_rvalid_o=0. A concurrent ls load response is still delivered.
- Reset mid-operation: assert rst=0 in the cycle after an if grant -> if_rvalid_o never asserts for that access.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_dmem_arbiter
// Purpose  : Shares the single-port 32x64k memory between fetch and LSU with
//            fixed LSU priority and a fetch starvation guard; optional
//            statistics counters enabled by IMEM_DMEM_ARB_STATS_EN.
// Revision : 1.0  initial release
// ============================================================================
module imem_dmem_arbiter #(
  parameter int ADDR       = 16,
  parameter int WORD       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req_i,
  input  logic [ADDR-1:0] if_addr_i,
  input  logic            if_flush_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [WORD-1:0] if_rdata_o,
  input  logic            ls_req_i,
  input  logic            ls_we_i,
  input  logic [ADDR-1:0] ls_addr_i,
  input  logic [WORD-1:0] ls_wdata_i,
  output logic            ls_gnt_o,
  output logic            ls_rvalid_o,
  output logic [WORD-1:0] ls_rdata_o,
  output logic [ADDR-1:0] mem_addr_o,
  output logic            mem_we_o,
  output logic [WORD-1:0] mem_d_o,
`ifdef IMEM_DMEM_ARB_STATS_EN
  output logic [31:0]     stat_if_o,
  output logic [31:0]     stat_ls_o,
  output logic [31:0]     stat_conflict_o,
`endif
  input  logic [WORD-1:0] mem_q_i
);

  localparam logic [1:0] OWN_IDLE  = 2'd0;
  localparam logic [1:0] OWN_RD_IF = 2'd1;
  localparam logic [1:0] OWN_RD_LS = 2'd2;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [1:0] owner_q, owner_d;
  logic       if_drop_q, if_drop_d;
  logic [3:0] starve_q, starve_d;
  logic       starve_hit;
  logic       if_win, ls_win;

  // Grants are masked during reset so every output reads 0 while rst is low.
  always_comb begin
    starve_hit = (starve_q == STARVE_LIM);
    if_win     = rst & if_req_i & (~ls_req_i | starve_hit);
    ls_win     = rst & ls_req_i & ~(if_req_i & starve_hit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_IDLE;
      if_drop_q <= 1'b0;
      starve_q  <= 4'd0;
    end else begin
      owner_q   <= owner_d;
      if_drop_q <= if_drop_d;
      starve_q  <= starve_d;
    end
  end

  always_comb begin
    owner_d   = OWN_IDLE;
    if_drop_d = 1'b0;
    starve_d  = 4'd0;
    if (if_win) begin
      owner_d   = OWN_RD_IF;
      if_drop_d = if_flush_i;
    end else if (ls_win && !ls_we_i) begin
      owner_d = OWN_RD_LS;
    end
    if (if_req_i && !if_win) begin
      starve_d = starve_hit ? starve_q : starve_q + 4'd1;
    end
  end

  always_comb begin
    if_gnt_o    = if_win;
    ls_gnt_o    = ls_win;
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_d_o     = '0;
    if (if_win) begin
      mem_addr_o = if_addr_i;
    end else if (ls_win) begin
      mem_addr_o = ls_addr_i;
      mem_we_o   = ls_we_i;
      mem_d_o    = ls_wdata_i;
    end
    // A flush in the grant cycle or in the response cycle both drop the word.
    if_rvalid_o = (owner_q == OWN_RD_IF) & ~if_drop_q & ~if_flush_i;
    ls_rvalid_o = (owner_q == OWN_RD_LS);
    if_rdata_o  = if_rvalid_o ? mem_q_i : '0;
    ls_rdata_o  = ls_rvalid_o ? mem_q_i : '0;
  end

`ifdef IMEM_DMEM_ARB_STATS_EN
  logic [31:0] stat_if_q, stat_ls_q, stat_conflict_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_if_q       <= 32'd0;
      stat_ls_q       <= 32'd0;
      stat_conflict_q <= 32'd0;
    end else begin
      if (if_win && stat_if_q != '1) begin
        stat_if_q <= stat_if_q + 32'd1;
      end
      if (ls_win && stat_ls_q != '1) begin
        stat_ls_q <= stat_ls_q + 32'd1;
      end
      if (if_req_i && ls_req_i && stat_conflict_q != '1) begin
        stat_conflict_q <= stat_conflict_q + 32'd1;
      end
    end
  end

  assign stat_if_o       = stat_if_q;
  assign stat_ls_o       = stat_ls_q;
  assign stat_conflict_o = stat_conflict_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_dmem_arbiter
// Purpose  : Directed scenarios plus randomized traffic against a behavioural
//            arbiter/memory model for imem_dmem_arbiter.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_dmem_arbiter;
  localparam int ADDR = 16;
  localparam int WORD = 32;
  localparam int SMAX = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            if_req = 1'b0, if_flush = 1'b0;
  logic [ADDR-1:0] if_addr = '0;
  logic            ls_req = 1'b0, ls_we = 1'b0;
  logic [ADDR-1:0] ls_addr = '0;
  logic [WORD-1:0] ls_wdata = '0;
  logic            if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_we;
  logic [WORD-1:0] if_rdata, ls_rdata, mem_d;
  logic [ADDR-1:0] mem_addr;
  logic [WORD-1:0] mem_q = '0;

  logic [WORD-1:0] mem     [0:65535];
  logic [WORD-1:0] ref_mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: starvation count and the one pending response per side.
  int              m_starve = 0;
  bit              m_pif = 0, m_pls = 0;
  logic [WORD-1:0] m_pif_d = '0, m_pls_d = '0;
  bit              last_ifg = 0, last_lsg = 0;

  always #5 clk = ~clk;

  imem_dmem_arbiter #(.ADDR(ADDR), .WORD(WORD), .STARVE_MAX(SMAX)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_flush_i (if_flush),
    .if_gnt_o   (if_gnt),
    .if_rvalid_o(if_rvalid),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_we_i    (ls_we),
    .ls_addr_i  (ls_addr),
    .ls_wdata_i (ls_wdata),
    .ls_gnt_o   (ls_gnt),
    .ls_rvalid_o(ls_rvalid),
    .ls_rdata_o (ls_rdata),
    .mem_addr_o (mem_addr),
    .mem_we_o   (mem_we),
    .mem_d_o    (mem_d),
    .mem_q_i    (mem_q)
  );

  // Single-port synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_d;
    mem_q <= mem[mem_addr];
  end

  function automatic logic [WORD-1:0] pat(input int a);
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  task automatic check_val(input string tag, input logic [WORD-1:0] got,
                           input logic [WORD-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called right after a falling edge with inputs applied; checks then advances one clock.
  task automatic cycle();
    bit              e_ifg, e_lsg;
    logic [ADDR-1:0] e_addr;
    #2;
    if (!rst) begin
      check_val("rst_gnt", {30'd0, if_gnt, ls_gnt}, 32'd0);
      check_val("rst_rvalid", {30'd0, if_rvalid, ls_rvalid}, 32'd0);
      check_val("rst_mem", {15'd0, mem_we, mem_addr}, 32'd0);
      check_val("rst_d", mem_d | if_rdata | ls_rdata, 32'd0);
      e_ifg = 0;
      e_lsg = 0;
    end else begin
      e_ifg  = if_req && (!ls_req || m_starve == SMAX);
      e_lsg  = ls_req && !e_ifg;
      e_addr = e_ifg ? if_addr : (e_lsg ? ls_addr : '0);
      check_val("if_gnt", {31'd0, if_gnt}, {31'd0, e_ifg});
      check_val("ls_gnt", {31'd0, ls_gnt}, {31'd0, e_lsg});
      check_val("mem_addr", {16'd0, mem_addr}, {16'd0, e_addr});
      check_val("mem_we", {31'd0, mem_we}, {31'd0, e_lsg && ls_we});
      check_val("mem_d", mem_d, e_lsg ? ls_wdata : '0);
      check_val("if_rvalid", {31'd0, if_rvalid}, {31'd0, m_pif && !if_flush});
      check_val("if_rdata", if_rdata, (m_pif && !if_flush) ? m_pif_d : '0);
      check_val("ls_rvalid", {31'd0, ls_rvalid}, {31'd0, m_pls});
      check_val("ls_rdata", ls_rdata, m_pls ? m_pls_d : '0);
    end
    @(posedge clk);
    if (!rst) begin
      m_starve = 0;
      m_pif    = 0;
      m_pls    = 0;
    end else begin
      m_starve = (if_req && !e_ifg) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
      m_pif    = e_ifg && !if_flush;
      m_pif_d  = ref_mem[if_addr];
      m_pls    = e_lsg && !ls_we;
      m_pls_d  = ref_mem[ls_addr];
      if (e_lsg && ls_we) ref_mem[ls_addr] = ls_wdata;
    end
    last_ifg = e_ifg;
    last_lsg = e_lsg;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = pat(i);
      ref_mem[i] = pat(i);
    end
    @(negedge clk);

    // Reset with both requests pending, then a lone fetch wins immediately.
    rst = 1'b0; if_req = 1'b1; ls_req = 1'b1; if_addr = 16'h0005; ls_addr = 16'h0006;
    cycle();
    cycle();
    rst = 1'b1; ls_req = 1'b0;
    #1 check_val("first_if_gnt", {31'd0, if_gnt}, 32'd1);
    cycle();

    // Back-to-back fetches with matching read data one cycle later.
    for (int k = 0; k < 5; k++) begin
      if_req  = (k < 3);
      if_addr = 16'(16'h0010 + k);
      if (k >= 1 && k <= 3) begin
        #1 check_val("b2b_rdata", if_rdata, pat(16'h0010 + k - 1));
      end
      cycle();
    end

    // Continuous contention: fetch forced through every fifth cycle.
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if_addr = 16'(i);
      ls_addr = 16'(16'h0040 + i);
      #1 check_val("starve_pat", {31'd0, if_gnt}, {31'd0, (i % 5) == 4});
      cycle();
    end

    // Store then load to the same word.
    if_req = 1'b0; ls_req = 1'b1; ls_we = 1'b1; ls_addr = 16'h0100; ls_wdata = 32'hDEADBEEF;
    #1 check_val("store_we", {31'd0, mem_we}, 32'd1);
    cycle();
    ls_we = 1'b0; ls_wdata = '0;
    #1 check_val("load_we", {31'd0, mem_we}, 32'd0);
    check_val("store_norv", {31'd0, ls_rvalid}, 32'd0);
    cycle();
    ls_req = 1'b0;
    #1 check_val("load_data", ls_rdata, 32'hDEADBEEF);
    cycle();

    // Flush drops the fetch response; the following load response is unaffected.
    if_req = 1'b1; if_addr = 16'h0020;
    cycle();
    if_req = 1'b0; if_flush = 1'b1; ls_req = 1'b1; ls_addr = 16'h0021;
    #1 check_val("flush_if", {31'd0, if_rvalid}, 32'd0);
    cycle();
    ls_req = 1'b0;
    #1 check_val("flush_ls", ls_rdata, pat(16'h0021));
    cycle();
    if_flush = 1'b0;

    // Reset asserted while a fetch response is in flight.
    if_req = 1'b1; if_addr = 16'h0030;
    cycle();
    if_req = 1'b0; rst = 1'b0;
    #1 check_val("midrst_rv", {31'd0, if_rvalid}, 32'd0);
    cycle();
    rst = 1'b1;
    cycle();
    cycle();

    // Randomized traffic; each requester holds its request until granted.
    for (int n = 0; n < 3000; n++) begin
      if (!if_req || last_ifg) begin
        if_req  = ($urandom_range(0, 99) < 60);
        if_addr = 16'($urandom_range(0, 63));
      end
      if (!ls_req || last_lsg) begin
        ls_req   = ($urandom_range(0, 99) < 55);
        ls_we    = ($urandom_range(0, 1) == 1);
        ls_addr  = 16'($urandom_range(0, 63));
        ls_wdata = $urandom;
      end
      if_flush = ($urandom_range(0, 9) == 0);
      cycle();
    end
    if_req = 1'b0; ls_req = 1'b0; if_flush = 1'b0;
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
